stream_dispatch: RTL and testbench

- Registered valid/ready front end for the parametric demultiplexer.
- Accepts one word per cycle together with a destination index and routes it through the demultiplexer.
- Holds the word in a one-entry slot per output channel until that channel's consumer accepts it.
- Sits between a single producer stream and 2**sel_bits independent consumers; isolates their back-pressure from each other.

---
 rtl/stream_dispatch.sv | 64 ++++++
 tb/tb_stream_dispatch.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/stream_dispatch.sv
// stream_dispatch: valid/ready front end that routes each word to one of
// 2**sel_bits one-entry output slots with independent back-pressure.
module stream_dispatch #(
  parameter int data_bits = 8,
  parameter int sel_bits  = 2,
  localparam int N = 1 << sel_bits
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [data_bits-1:0]           in_data,
  input  logic [sel_bits-1:0]            in_dest,
  input  logic                           in_valid,
  output logic                           in_ready,
  output logic [N-1:0][data_bits-1:0]    out_data,
  output logic [N-1:0]                   out_valid,
  input  logic [N-1:0]                   out_ready,
  output logic [sel_bits:0]              occupancy
);

  logic [N-1:0][data_bits-1:0] data_q, data_d;
  logic [N-1:0]                valid_q, valid_d;
  logic [sel_bits:0]           occ_q, occ_d;
  logic                        take;

  // Only the addressed slot gates acceptance; in_valid is never involved.
  assign in_ready = !rst &&
    (!valid_q[in_dest] || out_ready[in_dest]);
  assign take = in_valid && in_ready;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    occ_d   = '0;
    for (int i = 0; i < N; i++) begin
      if (valid_q[i] && out_ready[i]) begin
        valid_d[i] = 1'b0;
      end
      if (take && (in_dest == sel_bits'(i))) begin
        valid_d[i] = 1'b1;
        data_d[i]  = in_data;
      end
    end
    for (int i = 0; i < N; i++) begin
      occ_d = occ_d + {{sel_bits{1'b0}}, valid_d[i]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= '0;
      occ_q   <= '0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      occ_q   <= occ_d;
    end
  end

  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign occupancy = occ_q;

endmodule

// File: tb/tb_stream_dispatch.sv
// tb_stream_dispatch: directed and random checks of stream_dispatch
// against a per-channel scoreboard and slot-state model.
module tb_stream_dispatch;

  logic            clk = 1'b0;
  logic            rst;
  logic [7:0]      in_data;
  logic [1:0]      in_dest;
  logic            in_valid;
  logic            in_ready;
  logic [3:0][7:0] out_data;
  logic [3:0]      out_valid;
  logic [3:0]      out_ready;
  logic [2:0]      occupancy;

  int checks = 0;
  int errors = 0;
  int acc = 0;
  logic [3:0] mv = 4'b0;
  logic [7:0] sb [4][$];

  always #5 clk = ~clk;

  stream_dispatch #(.data_bits(8), .sel_bits(2)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_dest(in_dest),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .occupancy(occupancy)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] d,
                       input logic [7:0] x, input logic [3:0] r);
    in_valid  = v;
    in_dest   = d;
    in_data   = x;
    out_ready = r;
  endtask

  // One clock: check against model, advance model, cross the edge.
  task automatic tick();
    logic er;
    int d;
    #1;
    d  = int'(in_dest);
    er = !rst && (!mv[d] || out_ready[d]);
    chk("in_ready", {31'b0, in_ready}, {31'b0, er});
    chk("out_valid", {28'b0, out_valid}, {28'b0, mv});
    chk("occupancy", {29'b0, occupancy}, $countones(mv));
    for (int i = 0; i < 4; i++)
      if (mv[i]) chk("out_data", {24'b0, out_data[i]}, {24'b0, sb[i][0]});
    if (rst) begin
      mv = 4'b0;
      for (int i = 0; i < 4; i++) sb[i].delete();
    end else begin
      for (int i = 0; i < 4; i++)
        if (mv[i] && out_ready[i]) begin
          void'(sb[i].pop_front());
          mv[i] = 1'b0;
        end
      if (in_valid && er) begin
        sb[d].push_back(in_data);
        mv[d] = 1'b1;
        acc++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [2:0] occ0;
    int budget;
    rst = 1'b1;
    drive(1'b1, 2'd1, 8'hEE, 4'hF);
    @(posedge clk);
    #1;
    tick();
    tick();
    chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
    chk("rst_out_valid", {28'b0, out_valid}, 32'd0);
    chk("rst_occ", {29'b0, occupancy}, 32'd0);
    chk("rst_out_data", out_data, 32'd0);

    rst = 1'b0;
    drive(1'b1, 2'd2, 8'hA5, 4'h0);
    tick();
    chk("route_valid", {28'b0, out_valid}, 32'h4);
    chk("route_data2", {24'b0, out_data[2]}, 32'hA5);
    chk("route_occ", {29'b0, occupancy}, 32'd1);
    drive(1'b1, 2'd2, 8'h77, 4'h0);
    #1;
    chk("busy_dest2", {31'b0, in_ready}, 32'd0);
    tick();
    drive(1'b1, 2'd0, 8'h55, 4'h0);
    #1;
    chk("free_dest0", {31'b0, in_ready}, 32'd1);
    tick();

    drive(1'b0, 2'd0, 8'h00, 4'hF);
    tick();
    for (int d = 0; d < 4; d++) begin
      drive(1'b1, 2'(d), 8'h10 + 8'(d), 4'h0);
      tick();
    end
    chk("full_occ", {29'b0, occupancy}, 32'd4);
    for (int d = 0; d < 4; d++) begin
      in_dest = 2'(d);
      #1;
      chk("full_in_ready", {31'b0, in_ready}, 32'd0);
    end
    drive(1'b0, 2'd0, 8'h00, 4'b1000);
    tick();
    chk("rel3_occ", {29'b0, occupancy}, 32'd3);
    chk("rel3_valid", {28'b0, out_valid}, 32'h7);

    drive(1'b0, 2'd1, 8'h00, 4'b0010);
    tick();
    drive(1'b1, 2'd1, 8'h22, 4'b0000);
    tick();
    occ0 = occupancy;
    drive(1'b1, 2'd1, 8'h33, 4'b0010);
    #1;
    chk("refill_ready", {31'b0, in_ready}, 32'd1);
    tick();
    chk("refill_valid1", {31'b0, out_valid[1]}, 32'd1);
    chk("refill_data1", {24'b0, out_data[1]}, 32'h33);
    chk("refill_occ", {29'b0, occupancy}, {29'b0, occ0});

    drive(1'b0, 2'd0, 8'h00, 4'hF);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_valid", {28'b0, out_valid}, 32'd0);
    chk("mid_rst_occ", {29'b0, occupancy}, 32'd0);
    drive(1'b1, 2'd3, 8'h9C, 4'h0);
    tick();
    chk("post_rst_valid", {28'b0, out_valid}, 32'h8);
    chk("post_rst_data3", {24'b0, out_data[3]}, 32'h9C);
    drive(1'b0, 2'd0, 8'h00, 4'hF);
    tick();

    acc = 0;
    budget = 0;
    while (acc < 100 && budget < 2000) begin
      drive(1'b1, 2'($urandom_range(0, 3)), 8'($urandom),
            4'($urandom));
      tick();
      budget++;
    end
    chk("stream_count", acc, 32'd100);
    drive(1'b0, 2'd0, 8'h00, 4'hF);
    tick();
    tick();
    for (int i = 0; i < 4; i++)
      chk("stream_drained", sb[i].size(), 32'd0);
    chk("end_occ", {29'b0, occupancy}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
